// File: rtl/uart_prog_loader_if.sv
// Boot-loader bus: the received word stream coming in from the UART word
// receiver and the imem write port going out.
//
// Handshake: there is no ready. word_valid is a single-cycle pulse, and the
// loader samples word_in on every clock edge where word_valid=1. A word is
// never back-pressured. The loader drops a word if it is not expecting one
// (DONE/ERR), or if reload arrives in the same cycle. mem_we is a one-cycle
// write strobe. mem_addr and mem_wdata are only meaningful while mem_we=1,
// but they hold their last values otherwise.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [31:0]       word_in;
  logic              word_valid;
  logic              reload;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // The receiver side drives the words and reload, and the imem side gets the writes.
  modport master (
    output word_in, word_valid, reload,
    input  mem_we, mem_addr, mem_wdata
  );

  // This is the loader itself.
  modport slave (
    input  word_in, word_valid, reload,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader. It parses a header/payload/checksum image and writes
// the payload to imem at addresses 0..N-1. It keeps the core in reset until
// the XOR checksum of the image has matched.
module uart_prog_loader #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,          // asynchronous, active-low
  uart_prog_loader_if.slave   bus,
  output logic                cpu_rst,
  output logic                load_done,
  output logic                load_err,
  output logic                busy,
  output logic [ADDR_W:0]     words_loaded,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_WAIT_HDR  = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_CSUM = 3'd2,
    S_DONE      = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [31:0]       MAX_WORDS = 32'(1) << ADDR_W;

  state_t            state;
  logic [ADDR_W:0]   n_words;
  logic [31:0]       checksum;
  logic [TMO_W-1:0]  tmo_cnt;

  // The header is legal when it asks for at least one word and no more than imem holds.
  logic hdr_ok;
  assign hdr_ok = (bus.word_in != 32'd0) && (bus.word_in <= MAX_WORDS);

  assign state_dbg = state;

  // Loader FSM. Every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_WAIT_HDR;
      n_words       <= '0;
      checksum      <= '0;
      tmo_cnt       <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_rst       <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      busy          <= 1'b0;
      words_loaded  <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (bus.reload) begin
        // reload wins over a word arriving in the same cycle; that word is dropped
        state        <= S_WAIT_HDR;
        checksum     <= '0;
        tmo_cnt      <= '0;
        cpu_rst      <= 1'b1;
        load_done    <= 1'b0;
        load_err     <= 1'b0;
        busy         <= 1'b0;
        words_loaded <= '0;
      end else begin
        unique case (state)
          S_WAIT_HDR: begin
            if (bus.word_valid) begin
              if (hdr_ok) begin
                n_words  <= bus.word_in[ADDR_W:0];
                checksum <= '0;
                tmo_cnt  <= '0;
                busy     <= 1'b1;
                state    <= S_LOAD;
              end else begin
                load_err <= 1'b1;
                state    <= S_ERR;
              end
            end
          end

          S_LOAD: begin
            if (tmo_cnt == TMO_LIMIT) begin
              // sender went quiet: abandon the image, nothing more gets written
              load_err <= 1'b1;
              busy     <= 1'b0;
              state    <= S_ERR;
            end else if (bus.word_valid) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= words_loaded[ADDR_W-1:0];
              bus.mem_wdata <= bus.word_in;
              checksum      <= checksum ^ bus.word_in;
              words_loaded  <= words_loaded + CNT_ONE;
              tmo_cnt       <= '0;
              if (words_loaded + CNT_ONE == n_words) begin
                state <= S_WAIT_CSUM;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TMO_ONE;
            end
          end

          S_WAIT_CSUM: begin
            if (tmo_cnt == TMO_LIMIT) begin
              load_err <= 1'b1;
              busy     <= 1'b0;
              state    <= S_ERR;
            end else if (bus.word_valid) begin
              // the trailer is only compared against the checksum, never written to imem
              busy    <= 1'b0;
              tmo_cnt <= '0;
              if (bus.word_in == checksum) begin
                load_done <= 1'b1;
                cpu_rst   <= 1'b0;
                state     <= S_DONE;
              end else begin
                load_err <= 1'b1;
                state    <= S_ERR;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TMO_ONE;
            end
          end

          S_DONE: begin
            // the image is live; further words are ignored until reload
          end

          S_ERR: begin
            // sticky until reload or reset
          end

          default: begin
            state <= S_ERR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader. The reference model keeps every
// word received since the last reload or reset. It derives the expected
// writes and status from the image layout: header, N payload words, then the
// XOR trailer.
module tb_uart_prog_loader;

  localparam int ADDR_W = 4;
  localparam int TMO    = 100;
  localparam int MAXW   = 1 << ADDR_W;
  localparam int W      = ADDR_W + 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              cpu_rst, load_done, load_err, busy;
  logic [ADDR_W:0]   words_loaded;
  logic [2:0]        state_dbg;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .busy         (busy),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [31:0]   rx_q[$];
  logic [31:0]   img_q[$];
  bit            m_timeout = 1'b0;
  int            m_writes  = 0;
  int            we_count  = 0;
  logic [ADDR_W-1:0] m_last_addr = '0;
  logic [31:0]       m_last_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Count every write strobe the DUT produces, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) we_count++;
  end

  // ---------------- reference model ----------------
  function automatic bit m_hdr_ok();
    return rx_q.size() > 0 && rx_q[0] >= 32'd1 && rx_q[0] <= 32'(MAXW);
  endfunction

  function automatic int m_n();
    return int'(rx_q[0]);
  endfunction

  function automatic int m_loaded();
    if (!m_hdr_ok()) return 0;
    return (rx_q.size() - 1 < m_n()) ? rx_q.size() - 1 : m_n();
  endfunction

  function automatic bit m_trailer_seen();
    return m_hdr_ok() && rx_q.size() >= m_n() + 2;
  endfunction

  function automatic bit m_csum_ok();
    logic [31:0] x = '0;
    for (int i = 1; i <= m_n(); i++) x ^= rx_q[i];
    return rx_q[m_n() + 1] == x;
  endfunction

  function automatic bit m_done();
    return m_trailer_seen() && m_csum_ok();
  endfunction

  function automatic bit m_err();
    return (rx_q.size() > 0 && !m_hdr_ok()) || (m_trailer_seen() && !m_csum_ok()) || m_timeout;
  endfunction

  task automatic model_word(input logic [31:0] w);
    int idx;
    if (m_timeout) return;
    rx_q.push_back(w);
    idx = rx_q.size() - 1;
    if (m_hdr_ok() && idx >= 1 && idx <= m_n()) begin
      exp_q.push_back({ADDR_W'(idx - 1), w});
      m_last_addr = ADDR_W'(idx - 1);
      m_last_data = w;
      m_writes++;
    end
  endtask

  task automatic model_clear();
    rx_q.delete();
    exp_q.delete();
    m_timeout = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_status();
    check("words_loaded", words_loaded, m_loaded());
    check("load_done", load_done, m_done());
    check("load_err", load_err, m_err());
    check("cpu_rst", cpu_rst, !m_done());
    check("busy", busy, m_hdr_ok() && !m_done() && !m_err());
  endtask

  // Pulse one word; on return we sit at the falling edge after it was sampled.
  task automatic send(input logic [31:0] w);
    logic [W-1:0] e;
    bit exp_we;
    @(negedge clk);
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    @(negedge clk);
    bus.word_valid = 1'b0;
    model_word(w);
    exp_we = exp_q.size() > 0;
    check("mem_we", bus.mem_we, exp_we);
    if (exp_we) begin
      e = exp_q.pop_front();
      check("mem_addr", bus.mem_addr, e[W-1:32]);
      check("mem_wdata", bus.mem_wdata, e[31:0]);
    end else begin
      check("mem_addr_hold", bus.mem_addr, m_last_addr);
      check("mem_wdata_hold", bus.mem_wdata, m_last_data);
    end
    check_status();
  endtask

  task automatic send_image(input int max_gap);
    for (int i = 0; i < img_q.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send(img_q[i]);
    end
  endtask

  task automatic build_image(input int n, input bit corrupt);
    logic [31:0] x = '0;
    logic [31:0] w;
    img_q.delete();
    img_q.push_back(32'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      x ^= w;
      img_q.push_back(w);
    end
    img_q.push_back(corrupt ? (x ^ (32'd1 << $urandom_range(0, 31))) : x);
  endtask

  task automatic do_reload();
    @(negedge clk);
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
    model_clear();
    check("reload_mem_we", bus.mem_we, 1'b0);
    check_status();
  endtask

  task automatic check_we_total(input string tag);
    repeat (2) @(negedge clk);
    check(tag, we_count, m_writes);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.reload     = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check_status();
    reset = 1'b1;

    // nominal load
    img_q = '{32'd3, 32'h0000_0013, 32'h0010_0093, 32'h0020_8113, 32'h0030_8193};
    send_image(0);
    check("nominal_done", load_done, 1'b1);
    check_we_total("nominal_writes");

    // bad checksum
    do_reload();
    img_q = '{32'd3, 32'h0000_0013, 32'h0010_0093, 32'h0020_8113, 32'h0030_8192};
    send_image(0);
    check("badcsum_err", load_err, 1'b1);
    check_we_total("badcsum_writes");

    // header bounds
    do_reload();
    send(32'd0);
    send(32'h1234_5678);
    check_we_total("hdr0_writes");
    do_reload();
    send(32'(MAXW + 1));
    send(32'h0000_0001);
    check_we_total("hdr17_writes");
    do_reload();
    build_image(MAXW, 1'b0);
    send_image(1);
    check("full_last_addr", bus.mem_addr, MAXW - 1);
    check_we_total("full_writes");

    // timeout: header 2, one word, then silence
    do_reload();
    send(32'd2);
    send(32'hCAFE_F00D);
    k = 0;
    while (k < 3 * TMO) begin
      @(negedge clk);
      k++;
      if (load_err) break;
    end
    check("timeout_cycles", k, TMO + 1);
    m_timeout = 1'b1;
    check_status();
    send(32'hDEAD_BEEF);
    check_we_total("timeout_writes");

    // reload colliding with a payload word
    do_reload();
    send(32'd3);
    send(32'h1111_1111);
    @(negedge clk);
    bus.word_in    = 32'h2222_2222;
    bus.word_valid = 1'b1;
    bus.reload     = 1'b1;
    @(negedge clk);
    bus.word_valid = 1'b0;
    bus.reload     = 1'b0;
    model_clear();
    check("collide_mem_we", bus.mem_we, 1'b0);
    check_status();
    img_q = '{32'd3, 32'h0000_0013, 32'h0010_0093, 32'h0020_8113, 32'h0030_8193};
    send_image(0);
    check_we_total("collide_writes");

    // asynchronous reset in the middle of a load
    do_reload();
    send(32'd3);
    send(32'hAAAA_5555);
    send(32'h5555_AAAA);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    m_last_addr = '0;
    m_last_data = '0;
    check("arst_mem_we", bus.mem_we, 1'b0);
    check("arst_mem_addr", bus.mem_addr, 0);
    check("arst_mem_wdata", bus.mem_wdata, 0);
    check_status();
    @(negedge clk);
    reset = 1'b1;
    send(32'd2);             // stray word is taken as a header
    send(32'h0F0F_0F0F);
    send(32'hF0F0_0000);
    send(32'hFFFF_0F0F);
    check("arst_reload_done", load_done, 1'b1);
    check_we_total("arst_writes");

    // randomized images, gaps, corrupt trailers and bad headers
    for (int r = 0; r < 10; r++) begin
      do_reload();
      if ($urandom_range(0, 5) == 0) begin
        send($urandom_range(MAXW + 1, 32'hFFFF));
        send($urandom);
      end else begin
        build_image($urandom_range(1, MAXW), $urandom_range(0, 2) == 0);
        send_image(3);
        send($urandom);      // word after completion must be ignored
      end
      check_we_total("rand_writes");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Consumes the 32-bit words produced by the UART 32-bit word receiver (word bus plus one-cycle end pulse).
- Runs a header/payload/checksum boot protocol and writes the payload into instruction memory at consecutive word addresses.
- Holds the RISC-V core in reset until a complete, checksum-verified image has been loaded.
- Sits between the UART receive path and the imem write port.

Parameters:
ADDR_W, 10, imem word-address width; MAX_WORDS = 2**ADDR_W
TIMEOUT_CYCLES, 50_000_000, max clk cycles allowed between accepted words once loading has started

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset); one clock; reset is asynchronous and active-low
word_in  in  32  received word, valid only when word_valid=1
word_valid  in  1  one-cycle pulse, word_in valid (driven by receiver's data_end)
reload  in  1  one-cycle pulse, abort/restart loading from any state
mem_we  out  1  imem write enable, one cycle per payload word
mem_addr  out  ADDR_W  imem word address
mem_wdata  out  32  imem write data
cpu_rst  out  1  active-high core reset
load_done  out  1  level, image loaded and verified
load_err  out  1  level, protocol error
busy  out  1  high in LOAD and WAIT_CSUM
words_loaded  out  ADDR_W+1  count of payload words written

Behaviour:
- All outputs are registered.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, load_done=0, load_err=0, busy=0, words_loaded=0, state=WAIT_HDR, checksum=0, timeout counter=0.
- Protocol: header word N (payload word count) -> N payload words -> trailer word equal to the XOR of all N payload words.
- State WAIT_HDR:
  - On word_valid with 1 <= N <= MAX_WORDS: latch N, clear checksum, go to LOAD.
  - Otherwise (N=0 or N > MAX_WORDS): go to ERR.
  - No timeout applies in this state.
- State LOAD:
  - Each word_valid at cycle t produces mem_we=1 at t+1 with mem_addr = words_loaded (pre-increment value) and mem_wdata = word_in.
  - In the same cycle, checksum ^= word_in and words_loaded increments.
  - After the Nth word, go to WAIT_CSUM.
  - Addresses run 0..N-1 with no wrap; N=MAX_WORDS ends at address MAX_WORDS-1.
- State WAIT_CSUM:
  - On word_valid, compare word_in with checksum: equal -> DONE, else -> ERR.
  - The trailer word is never written to memory.
- State DONE:
  - load_done=1 and cpu_rst=0 from the cycle after the trailer pulse.
  - word_valid is ignored.
- State ERR:
  - load_err=1; cpu_rst stays 1; word_valid is ignored.
  - Leave only via reload or reset.
- Timeout:
  - The counter increments every cycle in LOAD and WAIT_CSUM and clears on each accepted word.
  - When the counter reaches TIMEOUT_CYCLES, go to ERR on the next edge; no further mem_we.
- mem_we is high for exactly one cycle per payload word. mem_addr and mem_wdata hold their last values when mem_we=0.
- reload: from any state, on the next edge:
  - state=WAIT_HDR, cpu_rst=1.
  - load_done, load_err, words_loaded, checksum and the timeout counter all clear.
  - reload has priority over a simultaneous word_valid; that word is dropped.
- Reset mid-load: all outputs return to reset values asynchronously. Words already written to imem are not undone.
- busy is high only in LOAD and WAIT_CSUM.

Test Plan:
1. Nominal load:
   - Stimulus: header 3, words 0x00000013, 0x00100093, 0x00208113, trailer 0x00308193.
   - Required: writes at addr 0/1/2, each one cycle after its pulse; load_done=1 and cpu_rst=0 one cycle after the trailer; words_loaded=3.
2. Bad checksum:
   - Stimulus: same image, trailer 0x00308192.
   - Required: three writes occur; load_err=1; cpu_rst stays 1; load_done stays 0.
3. Header bounds (ADDR_W=4):
   - Header 0 -> ERR with no mem_we.
   - Header 17 -> ERR.
   - Header 16 with 16 words and a correct trailer -> last write at addr 15, then DONE, with no wrap to 0.
4. Timeout (TIMEOUT_CYCLES=100):
   - Stimulus: header 2, one word, then silence.
   - Required: ERR reached exactly at the 100-cycle boundary; a late second word produces no mem_we.
5. reload collision:
   - Stimulus: reload pulsed in LOAD after 1 word, in the same cycle as a word_valid.
   - Required: word dropped, no mem_we, state WAIT_HDR, words_loaded=0; a fresh nominal load then succeeds from addr 0.
6. Async reset:
   - Stimulus: reset=0 asserted mid-LOAD between clock edges.
   - Required: outputs go to reset values immediately, with cpu_rst=1 and mem_we=0; after release, an ignored stray word is not treated as payload (it is parsed as a header).
